// File: rtl/regfile_write_buffer.sv
// ============================================================================
// Module   : regfile_write_buffer
// Brief    : Write-request FIFO in front of the 16x32 register file write port.
//            Optional read bypass compare enabled by REGFILE_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          rf_stall,
    output logic          rf_ld,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_data,
`ifdef REGFILE_WB_BYPASS_EN
    input  logic [AW-1:0] rd_addr,
    output logic          rd_hit,
    output logic [DW-1:0] rd_data,
`endif
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [AW-1:0] r_addr_mem [DEPTH];
    logic [DW-1:0] r_data_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = !w_empty && !rf_stall;

    assign in_ready = !w_full;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign rf_ld    = w_pop;
    assign rf_addr  = w_empty ? '0 : r_addr_mem[r_rd_ptr];
    assign rf_data  = w_empty ? '0 : r_data_mem[r_rd_ptr];

    // Array contents are left alone on reset; count gates every read of them.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_addr_mem[r_wr_ptr] <= in_addr;
            r_data_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Walk entries oldest to youngest so the last match wins.
    logic [PW-1:0] w_idx;

    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        w_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PW'(i);
            if ((CW'(i) < r_count) && (r_addr_mem[w_idx] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = r_data_mem[w_idx];
            end
        end
    end
`endif

endmodule

`default_nettype wire
